inst_fetch_queue: RTL

- Fetch stage upstream of the single-cycle decode/execute core.
- Owns the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/reset vector) that flush the queue and discard in-flight responses.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 52 +++++
 rtl/inst_fetch_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding, sizes, helpers.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int          INST_BYTES = 4;
  localparam int          INST_W     = 32;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;

  // Width of one queue entry: {pc, instruction}.
  function automatic int entry_w(input int addr_w);
    return INST_W + addr_w;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] cur, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head read directly from the storage registers.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop && (r_cnt != '0);
  // A push into a full queue is only accepted alongside a pop.
  assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_push_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head_data = r_mem[r_rd];
  assign o_count     = r_cnt;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: owns the PC, issues one imem request at a time, queues {pc,inst} for decode.
// Optional FETCH_STATS_EN adds saturating fetched/flushed counters.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                DEPTH    = 4,
  parameter  int                ADDR_W   = 32,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                CW       = $clog2(DEPTH) + 1,
  localparam int                EW       = entry_w(ADDR_W)
) (
  input  logic              clock,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_flushed,
`endif
  output logic [CW-1:0]     queue_count
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_addr;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_discard;
  logic [EW-1:0]     w_head;
  logic              w_unused;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_push      = 1'b0;
    w_discard   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!redirect_valid && (queue_count < CW'(DEPTH))) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          if (redirect_valid) w_discard = 1'b1;
          else                w_push    = 1'b1;
        end else if (redirect_valid) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // Stale response from before the redirect; the new PC is already loaded.
        if (imem_ack) begin
          w_state_nxt = IDLE;
          w_discard   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_addr <= r_fetch_pc;
      if (redirect_valid)
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (w_push)
        r_fetch_pc <= r_fetch_pc + ADDR_W'(INST_BYTES);
    end
  end

  assign imem_req  = (r_state != IDLE);
  assign imem_addr = r_addr;
  assign w_pop     = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_fifo (
    .clk        (clock),
    .i_rst      (rst),
    .i_flush    (redirect_valid),
    .i_push     (w_push),
    .i_push_data({r_fetch_pc, imem_rdata}),
    .i_pop      (w_pop),
    .o_head_data(w_head),
    .o_count    (queue_count)
  );

  assign inst_valid = (queue_count != '0);
  assign inst_data  = w_head[INST_W-1:0];
  assign inst_pc    = w_head[EW-1:INST_W];

`ifdef FETCH_STATS_EN
  logic [31:0] r_stat_fetched;
  logic [31:0] r_stat_flushed;
  logic [31:0] w_flush_inc;

  assign w_flush_inc = (redirect_valid ? 32'(queue_count) : 32'd0) + 32'(w_discard);

  always_ff @(posedge clock) begin
    if (rst) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      r_stat_fetched <= sat_add32(r_stat_fetched, 32'(w_push));
      r_stat_flushed <= sat_add32(r_stat_flushed, w_flush_inc);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
  assign w_unused     = ^redirect_pc[1:0];
`else
  assign w_unused     = ^{redirect_pc[1:0], w_discard};
`endif

endmodule
